// File: rtl/bird_physics.sv
// Bird physics: row position plus signed velocity, gravity and flap applied per game tick.
// Latency: a tick sampled at edge N updates head/tail/row/gameOver at that same edge.
// Backpressure: none; cont is a strobe, every tick is consumed, restart discards a coincident tick.
module bird_physics #(
  parameter int ROWS      = 8,
  parameter int PLANES    = 3,
  parameter int START_ROW = 4,
  parameter int FLAP_VEL  = 2,
  parameter int MAX_FALL  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     up,
  input  logic                     cont,
  input  logic                     restart,
  output logic [PLANES*ROWS-1:0]   head,
  output logic [PLANES*ROWS-1:0]   tail,
  output logic [$clog2(ROWS)-1:0]  row,
  output logic                     gameOver
);

  localparam int PW = $clog2(ROWS);
  // Two extra bits: one for the sign, one of headroom so pos + vel never wraps.
  localparam int NW = PW + 2;

  localparam logic        [PW-1:0] START_P = PW'(START_ROW);
  localparam logic signed [3:0]    FLAP_V  = 4'(FLAP_VEL);
  localparam logic signed [3:0]    MIN_V   = 4'(-MAX_FALL);
  localparam logic signed [NW-1:0] TOP_ROW = NW'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FLY, S_OVER} state_t;

  state_t                  r_state;
  logic [PW-1:0]           r_pos;
  logic signed [3:0]       r_vel;
  logic                    r_up_q;
  logic                    r_flap_pend;
  logic [PLANES*ROWS-1:0]  r_head;
  // The previous-tick row is kept only in its decoded, plane-replicated form.
  logic [PLANES*ROWS-1:0]  r_tail;
  logic                    r_game_over;

  logic                    w_up_rise;
  logic                    w_flap_now;
  logic signed [3:0]       w_vel_n;
  logic signed [NW-1:0]    w_pos_n;
  logic                    w_low;
  logic                    w_high;

  // One-hot row mask replicated into every colour plane.
  function automatic logic [PLANES*ROWS-1:0] f_mask(input logic [PW-1:0] p);
    logic [ROWS-1:0] oh;
    oh = ROWS'(1) << p;
    return {PLANES{oh}};
  endfunction

  assign w_up_rise  = up & ~r_up_q;
  assign w_flap_now = r_flap_pend | w_up_rise;

  // Velocity never sits below MIN_V, so clamping before the decrement avoids 4-bit wrap.
  assign w_vel_n = w_flap_now      ? FLAP_V :
                   (r_vel <= MIN_V) ? MIN_V  :
                                      r_vel - 4'sd1;

  assign w_pos_n = $signed({2'b00, r_pos}) + NW'(w_vel_n);
  assign w_low   = w_pos_n[NW-1];
  assign w_high  = ~w_low & (w_pos_n > TOP_ROW);

  // Game FSM with physics, flap latch and registered display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pos       <= START_P;
      r_vel       <= '0;
      r_up_q      <= 1'b0;
      r_flap_pend <= 1'b0;
      r_head      <= f_mask(START_P);
      r_tail      <= f_mask(START_P);
      r_game_over <= 1'b0;
    end else begin
      // Tracked in every state, including restart, so a held button never reads as a new edge.
      r_up_q <= up;
      if (restart) begin
        r_state     <= S_IDLE;
        r_pos       <= START_P;
        r_vel       <= '0;
        r_flap_pend <= 1'b0;
        r_head      <= f_mask(START_P);
        r_tail      <= f_mask(START_P);
        r_game_over <= 1'b0;
      end else if (r_state == S_OVER) begin
        r_flap_pend <= 1'b0;
      end else if (cont) begin
        r_flap_pend <= 1'b0;
        // IDLE hovers until a flap; FLY integrates on every tick.
        if (r_state == S_FLY || w_flap_now) begin
          r_tail <= f_mask(r_pos);
          if (w_low) begin
            r_state     <= S_OVER;
            r_pos       <= '0;
            r_head      <= f_mask('0);
            r_game_over <= 1'b1;
          end else if (w_high) begin
            r_state     <= S_OVER;
            r_pos       <= TOP_ROW[PW-1:0];
            r_head      <= f_mask(TOP_ROW[PW-1:0]);
            r_game_over <= 1'b1;
          end else begin
            r_state <= S_FLY;
            r_pos   <= w_pos_n[PW-1:0];
            r_vel   <= w_vel_n;
            r_head  <= f_mask(w_pos_n[PW-1:0]);
          end
        end
      end else if (w_up_rise) begin
        r_flap_pend <= 1'b1;
      end
    end
  end

  assign head     = r_head;
  assign tail     = r_tail;
  assign row      = r_pos;
  assign gameOver = r_game_over;

endmodule

// File: tb/tb_bird_physics.sv
// Bench for bird_physics at default parameters: directed scenarios then random stimulus.
// Every cycle is compared against a behavioural integer model of the game rules.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_bird_physics;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        up = 1'b0;
  logic        cont = 1'b0;
  logic        restart = 1'b0;
  logic [23:0] head;
  logic [23:0] tail;
  logic [2:0]  row;
  logic        gameOver;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: 0 = hovering, 1 = flying, 2 = game over.
  int m_st;
  int m_pos;
  int m_tail;
  int m_vel;
  bit m_pend;
  bit m_upq;

  always #5 clk = ~clk;

  bird_physics dut (
    .clk      (clk),
    .reset    (reset),
    .up       (up),
    .cont     (cont),
    .restart  (restart),
    .head     (head),
    .tail     (tail),
    .row      (row),
    .gameOver (gameOver)
  );

  function automatic int mask(input int p);
    return (1 << p) * 32'h010101;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_step();
    bit rise;
    bit fn;
    int vn;
    int pn;
    if (reset) begin
      m_st = 0; m_pos = 4; m_tail = 4; m_vel = 0; m_pend = 0; m_upq = 0;
    end else begin
      rise = up && !m_upq;
      fn   = m_pend || rise;
      if (restart) begin
        m_st = 0; m_pos = 4; m_tail = 4; m_vel = 0; m_pend = 0;
      end else if (m_st == 2) begin
        m_pend = 0;
      end else if (cont) begin
        m_pend = 0;
        if (m_st == 1 || fn) begin
          vn = fn ? 2 : ((m_vel - 1 < -2) ? -2 : m_vel - 1);
          pn = m_pos + vn;
          m_tail = m_pos;
          if (pn < 0) begin
            m_st = 2; m_pos = 0;
          end else if (pn > 7) begin
            m_st = 2; m_pos = 7;
          end else begin
            m_st = 1; m_pos = pn; m_vel = vn;
          end
        end
      end else if (rise) begin
        m_pend = 1;
      end
      m_upq = up;
    end
  endtask

  task automatic cyc(input bit u, input bit c, input bit r, input bit rs);
    @(negedge clk);
    up = u; cont = c; restart = r; reset = rs;
    @(posedge clk);
    model_step();
    #1;
    chk("model_head", head, mask(m_pos));
    chk("model_tail", tail, mask(m_tail));
    chk("model_row", row, m_pos);
    chk("model_gameOver", gameOver, (m_st == 2));
  endtask

  int exp_rows[8] = '{6, 7, 7, 6, 4, 2, 0, 0};

  initial begin
    // Reset state
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("rst_head", head, 24'h101010);
    chk("rst_tail", tail, 24'h101010);
    chk("rst_row", row, 4);
    chk("rst_gameOver", gameOver, 0);

    // Idle ticks without a flap leave the bird hovering
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 0);
      chk("idle_row", row, 4);
      chk("idle_head", head, 24'h101010);
      chk("idle_gameOver", gameOver, 0);
    end

    // Single flap pulse, then fall to the floor
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 0);
      chk("fall_row", row, exp_rows[i]);
      if (i == 0) chk("fall_first_tail", tail, 24'h101010);
    end
    chk("floor_head", head, 24'h010101);
    chk("floor_tail", tail, 24'h010101);
    chk("floor_gameOver", gameOver, 1);

    // OVER is frozen against ticks and flap edges
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("over_frozen_row", row, 0);
    chk("over_frozen_gameOver", gameOver, 1);

    // Restart with tick and held button: back to idle, no flap
    cyc(1, 1, 1, 0);
    chk("restart_head", head, 24'h101010);
    chk("restart_gameOver", gameOver, 0);
    cyc(1, 1, 0, 0);
    chk("restart_noflap_row", row, 4);
    cyc(0, 0, 0, 0);

    // Two flaps drive the bird through the ceiling
    cyc(1, 1, 0, 0);
    chk("ceil_row1", row, 6);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    chk("ceil_head", head, 24'h808080);
    chk("ceil_tail", tail, 24'h404040);
    chk("ceil_gameOver", gameOver, 1);
    cyc(0, 0, 1, 0);

    // Held button gives exactly one flap
    cyc(1, 1, 0, 0);
    chk("held_row1", row, 6);
    cyc(1, 1, 0, 0);
    chk("held_row2", row, 7);
    cyc(1, 1, 0, 0);
    chk("held_row3", row, 7);
    cyc(0, 0, 1, 0);

    // Edge between ticks is latched and applied at the next tick
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("latched_row1", row, 6);
    cyc(0, 1, 0, 0);
    chk("latched_row2", row, 7);

    // Reset together with restart mid-flight
    cyc(0, 0, 1, 1);
    chk("midfly_rst_head", head, 24'h101010);
    chk("midfly_rst_row", row, 4);
    chk("midfly_rst_gameOver", gameOver, 0);
    cyc(0, 1, 0, 0);
    chk("midfly_rst_idle_row", row, 4);

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) < 4, $urandom_range(0, 3) == 0,
          $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
